// File: rtl/bscan_chain_driver.sv
// Host-side boundary scan sequencer: one capture/shift/update pass per accepted start,
// serialising the load vector onto tdi while collecting tdo into capture_data_out.
module bscan_chain_driver #(
  parameter int unsigned CHAIN_LENGTH   = 32,
  parameter int unsigned CAPTURE_CYCLES = 2
) (
  input  logic                    tck,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    test_mode_req,
  input  logic [CHAIN_LENGTH-1:0] load_vector,
  input  logic                    tdo,
  output logic                    tdi,
  output logic [3:0]              control,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [CHAIN_LENGTH-1:0] capture_data_out
);

  localparam int unsigned CW = $clog2(CHAIN_LENGTH + 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(CAPTURE_CYCLES - 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LENGTH - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, DONE} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [CHAIN_LENGTH-1:0] tx, tx_n, rx, rx_n, cap_n;
  logic                    mode, mode_n;
  logic                    tdi_n, ready_n, busy_n, done_n;
  logic [3:0]              control_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tx_n    = tx;
    rx_n    = rx;
    mode_n  = mode;
    cap_n   = capture_data_out;
    unique case (state)
      IDLE: begin
        if (start) begin
          tx_n    = load_vector;
          mode_n  = test_mode_req;
          rx_n    = '0;
          cnt_n   = '0;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt == CAP_LAST) begin
          cnt_n   = '0;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          tx_n = tx << 1;
          rx_n = {rx[CHAIN_LENGTH-2:0], tdo};
          if (cnt == SHIFT_LAST) begin
            cnt_n   = '0;
            state_n = UPDATE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      UPDATE: begin
        // The update pulse has already reached the chain; abort only withholds the result.
        if (abort) begin
          state_n = IDLE;
        end else begin
          cap_n   = rx;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_comb begin
    tdi_n     = (state_n == SHIFT) ? tx_n[CHAIN_LENGTH-1] : 1'b0;
    ready_n   = (state_n == IDLE);
    busy_n    = (state_n == CAPTURE) || (state_n == SHIFT) || (state_n == UPDATE);
    done_n    = (state_n == DONE);
    control_n = {mode_n, state_n == UPDATE, state_n == SHIFT, state_n == CAPTURE};
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      tx               <= '0;
      rx               <= '0;
      mode             <= 1'b0;
      tdi              <= 1'b0;
      control          <= '0;
      ready            <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      capture_data_out <= '0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      tx               <= tx_n;
      rx               <= rx_n;
      mode             <= mode_n;
      tdi              <= tdi_n;
      control          <= control_n;
      ready            <= ready_n;
      busy             <= busy_n;
      done             <= done_n;
      capture_data_out <= cap_n;
    end
  end

endmodule

// File: tb/tb_bscan_chain_driver.sv
// Scoreboard bench for bscan_chain_driver: expected per-cycle outputs are queued by the
// stimulus from the operation timeline and checked by an independent monitor.
module tb_bscan_chain_driver;

  localparam int unsigned N = 8;
  localparam int unsigned C = 2;
  localparam int unsigned W = N + 8;

  logic         tck = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         test_mode_req = 1'b0;
  logic [N-1:0] load_vector = '0;
  logic         tdo = 1'b0;
  logic         tdi;
  logic [3:0]   control;
  logic         ready, busy, done;
  logic [N-1:0] capture_data_out;

  bscan_chain_driver #(.CHAIN_LENGTH(N), .CAPTURE_CYCLES(C)) dut (
    .tck(tck), .reset_n(reset_n), .start(start), .abort(abort),
    .test_mode_req(test_mode_req), .load_vector(load_vector), .tdo(tdo),
    .tdi(tdi), .control(control), .ready(ready), .busy(busy), .done(done),
    .capture_data_out(capture_data_out)
  );

  always #5 tck = ~tck;

  int cyc = 0;
  always @(posedge tck) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference state: latched mode and last completed capture
  logic         m_mode = 1'b0;
  logic [N-1:0] m_cap  = '0;

  function automatic logic [W-1:0] pack(input logic [3:0] ctl, input logic t, input logic r,
                                        input logic b, input logic d, input logic [N-1:0] cap);
    return {ctl, t, r, b, d, cap};
  endfunction

  function automatic logic [W-1:0] actual();
    return {control, tdi, ready, busy, done, capture_data_out};
  endfunction

  // monitor
  always @(negedge tck) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL stale_expectation cyc=%0d: expected entry for cyc %0d never checked", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = actual();
      n_cmp++;
      if (a !== e.v) begin
        n_bad++;
        $display("FAIL cycle_outputs cyc=%0d got ctl=%b tdi=%b rdy=%b busy=%b done=%b cap=%h want ctl=%b tdi=%b rdy=%b busy=%b done=%b cap=%h",
                 cyc, a[W-1:W-4], a[N+3], a[N+2], a[N+1], a[N], a[N-1:0],
                 e.v[W-1:W-4], e.v[N+3], e.v[N+2], e.v[N+1], e.v[N], e.v[N-1:0]);
      end
    end
  end

  task automatic check_now(input string name, input logic [W-1:0] want);
    logic [W-1:0] a;
    a = actual();
    n_cmp++;
    if (a !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, a, want);
    end
  endtask

  // Called at a negedge while the DUT is idle. abort_k/stray_k are offsets from the first
  // capture cycle (-1 = none); bits[j] is the tdo value presented in shift cycle j.
  task automatic run_op(input logic [N-1:0] lv, input logic mreq, input logic [N-1:0] bits,
                        input int abort_k, input int stray_k, input bit abort_with_start,
                        input int gap);
    int t, e, last;
    logic [N-1:0] cap_new;
    t = cyc;
    e = t + 1;
    m_mode = mreq;
    last = (abort_k >= 0) ? e + abort_k : e + int'(C + N + 1);
    for (int j = 0; j < int'(N); j++) cap_new[N-1-j] = bits[j];
    for (int c = e; c <= last; c++) begin
      int k;
      exp_t x;
      k = c - e;
      x.cyc = c;
      if (k < int'(C))
        x.v = pack({m_mode, 3'b001}, 1'b0, 1'b0, 1'b1, 1'b0, m_cap);
      else if (k < int'(C + N))
        x.v = pack({m_mode, 3'b010}, lv[N-1-(k-int'(C))], 1'b0, 1'b1, 1'b0, m_cap);
      else if (k == int'(C + N))
        x.v = pack({m_mode, 3'b100}, 1'b0, 1'b0, 1'b1, 1'b0, m_cap);
      else begin
        m_cap = cap_new;
        x.v = pack({m_mode, 3'b000}, 1'b0, 1'b0, 1'b0, 1'b1, m_cap);
      end
      exp_q.push_back(x);
    end
    for (int c = last + 1; c <= last + 1 + gap; c++) begin
      exp_t x;
      x.cyc = c;
      x.v = pack({m_mode, 3'b000}, 1'b0, 1'b1, 1'b0, 1'b0, m_cap);
      exp_q.push_back(x);
    end
    for (int c = t; c <= last + gap; c++) begin
      int k;
      k = c - e;
      start = (c == t) || (stray_k >= 0 && k == stray_k);
      if (c == t) begin
        load_vector   = lv;
        test_mode_req = mreq;
      end else if (start) begin
        load_vector   = ~lv;
        test_mode_req = ~mreq;
      end
      abort = (c == t && abort_with_start) || (abort_k >= 0 && k == abort_k);
      if (k >= int'(C) && k < int'(C + N)) tdo = bits[k-int'(C)];
      else tdo = 1'($urandom_range(1));
      @(negedge tck);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic random_op();
    int ak, sk, last_k;
    ak = ($urandom_range(2) == 0) ? int'($urandom_range(C + N)) : -1;
    last_k = (ak >= 0) ? ak : int'(C + N + 1);
    sk = ($urandom_range(1) == 0) ? int'($urandom_range(last_k)) : -1;
    run_op(N'($urandom), 1'($urandom_range(1)), N'($urandom), ak, sk,
           1'($urandom_range(1)), int'($urandom_range(3)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge tck);
    check_now("reset_state", pack(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, '0));
    reset_n = 1'b1;
    @(negedge tck);

    // all-ones tdo: capture FF, tdi walks 3C MSB first, done at cycle C+N+2
    run_op(8'h3C, 1'b1, 8'hFF, -1, -1, 1'b0, 1);
    // start with abort in idle is accepted; stray start mid-shift is ignored
    run_op(8'h96, 1'b0, 8'hA5, -1, int'(C + 2), 1'b1, 0);
    // abort in the 4th shift cycle, in capture, and in update
    run_op(8'h5A, 1'b1, 8'h0F, int'(C + 3), -1, 1'b0, 2);
    run_op(8'hC3, 1'b0, 8'h81, 0, -1, 1'b0, 0);
    run_op(8'h77, 1'b1, 8'h42, int'(C + N), int'(C + 1), 1'b0, 1);
    for (int i = 0; i < 30; i++) random_op();

    // asynchronous reset mid-shift
    start = 1'b1; load_vector = 8'hE7; test_mode_req = 1'b1;
    @(negedge tck);
    start = 1'b0;
    repeat (C + 3) @(negedge tck);
    #2 reset_n = 1'b0;
    #1 check_now("async_reset_mid_shift", pack(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, '0));
    @(negedge tck);
    check_now("reset_held", pack(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, '0));
    reset_n = 1'b1;
    m_mode = 1'b0;
    m_cap  = '0;
    @(negedge tck);
    run_op(8'h3C, 1'b1, 8'h5A, -1, -1, 1'b0, 1);
    for (int i = 0; i < 4; i++) random_op();

    repeat (3) @(negedge tck);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
